priority_arbiter_8: RTL and testbench
=====================================

# priority_arbiter_8

Registered 8-requester arbiter that shares one resource slot, such as the downstream port fed by the 8-to-3 priority encoder path. It grants one requester at a time and holds the grant while that requester keeps its request high. A hold-limit timer forces release when the owner overstays and another requester is waiting. Fixed bit-7-highest priority matches the encoder's ordering; round-robin fairness is a compile-time option.

## Interface
Parameters:
- MAX_HOLD, 16: grant cycles before forced release when other requests are pending. Legal range 1–255. 0 means unlimited (no forced release).

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req  input  8  request vector; req[i] high = requester i wants or holds the resource
- gnt  output  8  one-hot grant, registered; all zero when idle
- gnt_idx  output  3  binary index of the granted requester; 0 when idle
- gnt_valid  output  1  high while any grant is active (equals |gnt)
- hold_cnt  output  8  cycles the current owner has held the grant; 0 when idle

## Operation
- Two states:
  - IDLE: no owner.
  - GRANT: owner = gnt_idx.
- Candidate set is req with the current owner's bit masked off while in GRANT.
- Winner selection, fixed priority (default): highest set index wins (bit 7 > … > bit 0).
- IDLE:
  - If req != 0: winner goes to GRANT; gnt, gnt_idx and gnt_valid load; hold_cnt = 1.
  - Otherwise stay in IDLE.
- GRANT, owner releases (req[owner] = 0):
  - If the candidate set is non-empty: grant its winner at the same edge (back-to-back, no idle cycle); hold_cnt = 1.
  - Else go to IDLE with all outputs cleared.
- GRANT, timeout (MAX_HOLD != 0, hold_cnt == MAX_HOLD, candidate set non-empty):
  - Forced handover to the candidate winner at that edge; hold_cnt = 1.
  - The old owner may re-win later only by normal arbitration.
- GRANT, no release and no timeout: keep owner; hold_cnt increments, saturating at MAX_HOLD (255 when MAX_HOLD = 0).
- Owner release takes precedence over timeout; both take the same handover path.
- gnt is always one-hot or zero; gnt_idx always agrees with gnt.

## Timing
- Reset: gnt = 8'h00, gnt_idx = 0, gnt_valid = 0, hold_cnt = 0, state = IDLE, round-robin pointer = 0.
- Reset mid-grant clears everything at that edge; requests sampled in the reset cycle are ignored.
- Grant latency: req sampled at edge t → gnt visible after edge t (one cycle, registered).
- Release latency: owner drops req before edge t → gnt changes at edge t.
- Requests arriving in the same cycle are resolved by priority only; there is no request queueing.
- A requester dropping req before it is granted is simply not considered.

## Configuration
- ARB_ROUND_ROBIN_EN defined:
  - A 3-bit pointer records the last granted index; it updates on every grant.
  - Search order starts at pointer−1 and descends, wrapping 0→7. The last winner has lowest priority next time.
  - Pointer resets to 0, so the first search order is 7…0, identical to fixed priority.
- ARB_ROUND_ROBIN_EN undefined:
  - Pure fixed priority, bit 7 highest; the pointer logic is absent.
  - Timeout masking of the owner still applies.

## Test plan
- Reset/idle: hold rst for 2 cycles with req = 8'hFF → outputs all zero. Release rst → next edge gnt = 8'h80, gnt_idx = 7, hold_cnt = 1.
- Simultaneous requests, fixed priority: req = 8'b01010110 from idle → gnt = 8'h40, gnt_idx = 6. Drop bit 6 → next edge gnt = 8'h10, idx = 4, no idle cycle. Then drop bit 4 → idx 2 → idx 1 → idle, gnt = 0.
- Hold lock: req = 8'h01 granted. Raise req = 8'h81 while bit 0 is held (MAX_HOLD = 16) → gnt stays 8'h01 until hold_cnt reaches 16. On that edge gnt = 8'h80, hold_cnt = 1.
- Saturation: single req = 8'h08 held 40 cycles, MAX_HOLD = 16 → gnt = 8'h08 throughout, hold_cnt stays at 16.
- Round robin (ARB_ROUND_ROBIN_EN): req = 8'hFF constant, MAX_HOLD = 1 → grant sequence 7, 6, 5, …, 0, 7. Each owner held exactly 1 cycle.
- Mid-grant reset: owner 3 at hold_cnt = 5, assert rst one cycle → all outputs 0. After reset, req = 8'h08 → gnt = 8'h08 with hold_cnt = 1.

Source files
------------

// File: rtl/priority_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and priority_arbiter_8 (slave).
interface priority_arbiter_8_if;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic [7:0] hold_cnt;

  modport master (
    output req,
    input  gnt,
    input  gnt_idx,
    input  gnt_valid,
    input  hold_cnt
  );

  modport slave (
    input  req,
    output gnt,
    output gnt_idx,
    output gnt_valid,
    output hold_cnt
  );
endinterface

// File: rtl/priority_arbiter_8.sv
// Registered 8-requester arbiter with grant hold and hold-limit forced release.
// Optional round-robin search order enabled by defining ARB_ROUND_ROBIN_EN.
module priority_arbiter_8 #(
  parameter int MAX_HOLD = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  priority_arbiter_8_if.slave   bus
);

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  // MAX_HOLD = 0 disables forced release; the counter then saturates at 255.
  localparam logic [7:0] HOLD_CAP   = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD);
  localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);

  state_t     state_p0, state_nxt;
  logic [2:0] owner_p0, owner_nxt;
  logic [7:0] hold_p0,  hold_nxt;

  logic [7:0] cand;
  logic       owner_keeps;
  logic       timeout;
  logic       grant_load;
  logic       win_found;
  logic [2:0] win_idx;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v >= HOLD_CAP) ? HOLD_CAP : v + 8'd1;
  endfunction

  // Later loop iterations overwrite earlier ones, so the highest set bit wins.
  function automatic logic [3:0] pick_fixed(input logic [7:0] c);
    logic [3:0] r;
    r = 4'b0000;
    for (int i = 0; i < 8; i++) begin
      if (c[i]) r = {1'b1, 3'(i)};
    end
    return r;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  // Scan from lowest priority (ptr itself) up to highest (ptr-1); last hit wins.
  function automatic logic [3:0] pick_rr(input logic [7:0] c, input logic [2:0] p);
    logic [3:0] r;
    logic [2:0] idx;
    r = 4'b0000;
    for (int s = 8; s >= 1; s--) begin
      idx = p - 3'(s);
      if (c[idx]) r = {1'b1, idx};
    end
    return r;
  endfunction

  logic [2:0] ptr_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_p0 <= 3'd0;
    end else if (grant_load) begin
      ptr_p0 <= win_idx;
    end
  end

  assign {win_found, win_idx} = pick_rr(cand, ptr_p0);
`else
  assign {win_found, win_idx} = pick_fixed(cand);
`endif

  // ---- stage p0: arbitration state register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_p0 <= IDLE;
      owner_p0 <= 3'd0;
      hold_p0  <= 8'd0;
    end else begin
      state_p0 <= state_nxt;
      owner_p0 <= owner_nxt;
      hold_p0  <= hold_nxt;
    end
  end

  always_comb begin
    cand = bus.req;
    if (state_p0 == GRANT) cand[owner_p0] = 1'b0;
    owner_keeps = (state_p0 == GRANT) && bus.req[owner_p0];
    timeout     = TIMEOUT_EN && (hold_p0 == HOLD_CAP);
    grant_load  = win_found && ((state_p0 == IDLE) || !owner_keeps || timeout);

    state_nxt = state_p0;
    owner_nxt = owner_p0;
    hold_nxt  = hold_p0;
    unique case (state_p0)
      IDLE: begin
        if (win_found) begin
          state_nxt = GRANT;
          owner_nxt = win_idx;
          hold_nxt  = 8'd1;
        end
      end
      GRANT: begin
        if (grant_load) begin
          owner_nxt = win_idx;
          hold_nxt  = 8'd1;
        end else if (!owner_keeps) begin
          state_nxt = IDLE;
          owner_nxt = 3'd0;
          hold_nxt  = 8'd0;
        end else begin
          hold_nxt  = sat_inc(hold_p0);
        end
      end
      default: begin
        state_nxt = IDLE;
        owner_nxt = 3'd0;
        hold_nxt  = 8'd0;
      end
    endcase
  end

  // Outputs decode only registered state, so they change solely at clock edges.
  always_comb begin
    bus.gnt       = (state_p0 == GRANT) ? (8'd1 << owner_p0) : 8'd0;
    bus.gnt_idx   = owner_p0;
    bus.gnt_valid = (state_p0 == GRANT);
    bus.hold_cnt  = hold_p0;
  end

endmodule

// File: tb/tb_priority_arbiter_8.sv
// Randomized and directed bench for priority_arbiter_8 (MAX_HOLD = 16 and MAX_HOLD = 1 instances).
module tb_priority_arbiter_8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  priority_arbiter_8_if bus_a ();
  priority_arbiter_8_if bus_b ();

  priority_arbiter_8 #(.MAX_HOLD(16)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
  priority_arbiter_8 #(.MAX_HOLD(1))  dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

  int total  = 0;
  int passed = 0;

  // Reference model: owner index (-1 = idle), hold count, pointer per instance.
  int own [2];
  int hold[2];
  int lim [2] = '{16, 1};
`ifdef ARB_ROUND_ROBIN_EN
  int ptr [2];
`endif

  function automatic int pick_fixed(input logic [7:0] c);
    for (int i = 7; i >= 0; i--) if (c[i]) return i;
    return -1;
  endfunction

`ifdef ARB_ROUND_ROBIN_EN
  function automatic int pick_rr(input logic [7:0] c, input int p);
    for (int s = 1; s <= 8; s++) begin
      int i;
      i = (p - s + 16) % 8;
      if (c[i]) return i;
    end
    return -1;
  endfunction
`endif

  task automatic model_step(input int k, input logic [7:0] r, input bit rs);
    int cap, w;
    logic [7:0] cand;
    bit keeps, expired;
    if (rs) begin
      own[k] = -1; hold[k] = 0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr[k] = 0;
`endif
      return;
    end
    cap = (lim[k] == 0) ? 255 : lim[k];
    cand = r;
    if (own[k] >= 0) cand[own[k]] = 1'b0;
    keeps   = (own[k] >= 0) && r[own[k]];
    expired = (lim[k] != 0) && (hold[k] == lim[k]);
`ifdef ARB_ROUND_ROBIN_EN
    w = pick_rr(cand, ptr[k]);
`else
    w = pick_fixed(cand);
`endif
    if (keeps && !(expired && w >= 0)) begin
      hold[k] = (hold[k] + 1 > cap) ? cap : hold[k] + 1;
    end else if (w >= 0) begin
      own[k] = w; hold[k] = 1;
`ifdef ARB_ROUND_ROBIN_EN
      ptr[k] = w;
`endif
    end else begin
      own[k] = -1; hold[k] = 0;
    end
  endtask

  task automatic tick(input logic [7:0] r, input bit rs);
    @(negedge clk);
    rst = rs;
    bus_a.req = r;
    bus_b.req = r;
    @(posedge clk);
    model_step(0, r, rs);
    model_step(1, r, rs);
    #1;
  endtask

  task automatic test_reset();
    tick(8'hFF, 1'b1);
    tick(8'hFF, 1'b1);
    total++; if (bus_a.gnt !== 8'h00) $display("FAIL reset_gnt got=%h exp=00", bus_a.gnt); else passed++;
    total++; if (bus_a.gnt_idx !== 3'd0) $display("FAIL reset_idx got=%0d exp=0", bus_a.gnt_idx); else passed++;
    total++; if (bus_a.gnt_valid !== 1'b0) $display("FAIL reset_valid got=%b exp=0", bus_a.gnt_valid); else passed++;
    total++; if (bus_a.hold_cnt !== 8'd0) $display("FAIL reset_hold got=%0d exp=0", bus_a.hold_cnt); else passed++;
    tick(8'hFF, 1'b0);
    total++; if (bus_a.gnt !== 8'h80) $display("FAIL first_gnt got=%h exp=80", bus_a.gnt); else passed++;
    total++; if (bus_a.gnt_idx !== 3'd7) $display("FAIL first_idx got=%0d exp=7", bus_a.gnt_idx); else passed++;
    total++; if (bus_a.hold_cnt !== 8'd1) $display("FAIL first_hold got=%0d exp=1", bus_a.hold_cnt); else passed++;
  endtask

  task automatic test_priority_chain();
    logic [7:0] seq_req [5] = '{8'b01010110, 8'b00010110, 8'b00000110, 8'b00000010, 8'b00000000};
    logic [7:0] seq_gnt [5] = '{8'h40, 8'h10, 8'h04, 8'h02, 8'h00};
    tick(8'h00, 1'b0);
    total++; if (bus_a.gnt !== 8'h00) $display("FAIL chain_idle got=%h exp=00", bus_a.gnt); else passed++;
    for (int i = 0; i < 5; i++) begin
      tick(seq_req[i], 1'b0);
      total++;
      if (bus_a.gnt !== seq_gnt[i] || bus_a.gnt_valid !== (seq_gnt[i] != 8'h00))
        $display("FAIL chain_step%0d got=%h/%b exp=%h", i, bus_a.gnt, bus_a.gnt_valid, seq_gnt[i]);
      else passed++;
    end
  endtask

  task automatic test_hold_lock();
    tick(8'h01, 1'b0);
    total++; if (bus_a.gnt !== 8'h01) $display("FAIL lock_start got=%h exp=01", bus_a.gnt); else passed++;
    for (int i = 0; i < 15; i++) begin
      tick(8'h81, 1'b0);
      total++;
      if (bus_a.gnt !== 8'h01 || bus_a.hold_cnt !== 8'(i + 2))
        $display("FAIL lock_hold%0d got=%h/%0d exp=01/%0d", i, bus_a.gnt, bus_a.hold_cnt, i + 2);
      else passed++;
    end
    tick(8'h81, 1'b0);
    total++;
    if (bus_a.gnt !== 8'h80 || bus_a.hold_cnt !== 8'd1)
      $display("FAIL lock_timeout got=%h/%0d exp=80/1", bus_a.gnt, bus_a.hold_cnt);
    else passed++;
    tick(8'h00, 1'b0);
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 40; i++) begin
      tick(8'h08, 1'b0);
      total++;
      if (bus_a.gnt !== 8'h08 || bus_a.hold_cnt !== 8'((i + 1 > 16) ? 16 : i + 1))
        $display("FAIL sat_cycle%0d got=%h/%0d exp=08/%0d", i, bus_a.gnt, bus_a.hold_cnt, (i + 1 > 16) ? 16 : i + 1);
      else passed++;
    end
    total++; if (bus_b.hold_cnt !== 8'd1) $display("FAIL sat_lim1 got=%0d exp=1", bus_b.hold_cnt); else passed++;
    tick(8'h00, 1'b0);
  endtask

  task automatic test_round_robin();
    int exp_idx;
    tick(8'hFF, 1'b1);
    for (int i = 0; i < 9; i++) begin
      tick(8'hFF, 1'b0);
`ifdef ARB_ROUND_ROBIN_EN
      exp_idx = (15 - i) % 8;
`else
      exp_idx = (i % 2 == 0) ? 7 : 6;
`endif
      total++;
      if (bus_b.gnt_idx !== 3'(exp_idx) || bus_b.hold_cnt !== 8'd1)
        $display("FAIL rr_step%0d got=%0d/%0d exp=%0d/1", i, bus_b.gnt_idx, bus_b.hold_cnt, exp_idx);
      else passed++;
    end
    tick(8'h00, 1'b0);
  endtask

  task automatic test_mid_reset();
    for (int i = 0; i < 5; i++) tick(8'h08, 1'b0);
    total++;
    if (bus_a.gnt_idx !== 3'd3 || bus_a.hold_cnt !== 8'd5)
      $display("FAIL midrst_pre got=%0d/%0d exp=3/5", bus_a.gnt_idx, bus_a.hold_cnt);
    else passed++;
    tick(8'h08, 1'b1);
    total++;
    if (bus_a.gnt !== 8'h00 || bus_a.gnt_valid !== 1'b0 || bus_a.hold_cnt !== 8'd0 || bus_a.gnt_idx !== 3'd0)
      $display("FAIL midrst_clear got=%h/%b/%0d exp=00/0/0", bus_a.gnt, bus_a.gnt_valid, bus_a.hold_cnt);
    else passed++;
    tick(8'h08, 1'b0);
    total++;
    if (bus_a.gnt !== 8'h08 || bus_a.hold_cnt !== 8'd1)
      $display("FAIL midrst_regrant got=%h/%0d exp=08/1", bus_a.gnt, bus_a.hold_cnt);
    else passed++;
  endtask

  task automatic test_random();
    logic [7:0] r;
    logic [7:0] g, eg, h;
    logic [2:0] ix, eix;
    logic       v;
    bit         rs;
    int         mode;
    r = 8'h00;
    for (int c = 0; c < 3000; c++) begin
      mode = $urandom_range(0, 9);
      if (mode < 2) r = 8'($urandom);
      else if (mode < 5) r[$urandom_range(0, 7)] = ~r[$urandom_range(0, 7)];
      rs = ($urandom_range(0, 199) == 0);
      tick(r, rs);
      for (int k = 0; k < 2; k++) begin
        if (k == 0) begin g = bus_a.gnt; ix = bus_a.gnt_idx; v = bus_a.gnt_valid; h = bus_a.hold_cnt; end
        else        begin g = bus_b.gnt; ix = bus_b.gnt_idx; v = bus_b.gnt_valid; h = bus_b.hold_cnt; end
        eg  = (own[k] < 0) ? 8'h00 : (8'h01 << own[k]);
        eix = (own[k] < 0) ? 3'd0 : 3'(own[k]);
        total++;
        if (g !== eg) $display("FAIL rand_gnt dut%0d cyc%0d req=%h got=%h exp=%h", k, c, r, g, eg); else passed++;
        total++;
        if (ix !== eix) $display("FAIL rand_idx dut%0d cyc%0d got=%0d exp=%0d", k, c, ix, eix); else passed++;
        total++;
        if (v !== (own[k] >= 0)) $display("FAIL rand_valid dut%0d cyc%0d got=%b exp=%b", k, c, v, own[k] >= 0); else passed++;
        total++;
        if (h !== 8'(hold[k])) $display("FAIL rand_hold dut%0d cyc%0d got=%0d exp=%0d", k, c, h, hold[k]); else passed++;
      end
    end
  endtask

  initial begin
    bus_a.req = 8'h00;
    bus_b.req = 8'h00;
    own  = '{-1, -1};
    hold = '{0, 0};
`ifdef ARB_ROUND_ROBIN_EN
    ptr  = '{0, 0};
`endif
    test_reset();
    test_priority_chain();
    test_hold_lock();
    test_saturation();
    test_round_robin();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
